// File: rtl/aes_192_wb_master_pkg.sv
// Shared definitions for the AES-192 Wishbone initiator.
// Holds the slave register word indices, the sequencer state encoding,
// the counter widths and a helper that turns a word index into a byte address.
package aes_wb_pkg;

  localparam int WORD_W     = 4;
  localparam int XFER_CNT_W = 3;
  localparam int POLL_CNT_W = 11;
  localparam int GAP_CNT_W  = 8;

  localparam logic [WORD_W-1:0] START = 4'd0;
  localparam logic [WORD_W-1:0] DATA0 = 4'd1;
  localparam logic [WORD_W-1:0] KEY0  = 4'd5;
  localparam logic [WORD_W-1:0] READY = 4'd11;
  localparam logic [WORD_W-1:0] RES0  = 4'd12;

  typedef enum logic [2:0] {
    IDLE,
    WR_KEY,
    WR_DATA,
    WR_START,
    POLL,
    RD_RES,
    RESP
  } state_t;

  // Byte address of 32-bit word 'idx' relative to the slave base.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [WORD_W-1:0] idx);
    return base + {26'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/aes_192_wb_master_if.sv
// Wishbone classic bus bundle between the AES initiator and the AES slave.
// Signal names keep the initiator's point of view (_o driven by the master).
interface aes_192_wb_master_if;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/aes_192_wb_master_wb_single_xfer.sv
// One-transfer Wishbone classic engine.
// A request seen while the bus is idle launches exactly one cycle; the cycle
// holds address/data/we until ack or err, then the bus is forced idle for at
// least one clock because a new request is only sampled while cyc is low.
// done/err/rdat are combinational from the slave response so the sequencer
// can present its next request during that idle clock.
module wb_single_xfer
  import aes_wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wdat,
  output logic        done,
  output logic        err,
  output logic [31:0] rdat,
  aes_192_wb_master_if.master wb
);

  assign done = wb.wb_cyc_o & (wb.wb_ack_i | wb.wb_err_i);
  assign err  = wb.wb_cyc_o & wb.wb_err_i;
  assign rdat = wb.wb_dat_i;

  // Launch a cycle from idle, hold it until the slave answers, then drop to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_sel_o <= 4'h0;
      wb.wb_adr_o <= 32'h0;
      wb.wb_dat_o <= 32'h0;
    end else if (wb.wb_cyc_o) begin
      if (wb.wb_ack_i || wb.wb_err_i) begin
        wb.wb_cyc_o <= 1'b0;
        wb.wb_stb_o <= 1'b0;
        wb.wb_we_o  <= 1'b0;
        wb.wb_sel_o <= 4'h0;
        wb.wb_adr_o <= 32'h0;
        wb.wb_dat_o <= 32'h0;
      end
    end else if (req) begin
      wb.wb_cyc_o <= 1'b1;
      wb.wb_stb_o <= 1'b1;
      wb.wb_we_o  <= we;
      wb.wb_sel_o <= 4'hF;
      wb.wb_adr_o <= adr;
      wb.wb_dat_o <= wdat;
    end
  end

endmodule

// File: rtl/aes_192_wb_master.sv
// AES-192 Wishbone initiator: takes one key/plaintext command, drives the AES
// slave register map (key, data, start, poll ready, read result) and returns
// the ciphertext with an error flag on the response port.
// Optional build macro AES_WBM_KEY_CACHE_EN: remember the last key written
// successfully and skip the six key writes when the next command reuses it.
module aes_192_wb_master
  import aes_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          POLL_MAX  = 1024,
  parameter int          POLL_GAP  = 2
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [191:0] cmd_key,
  input  logic [127:0] cmd_pt,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [127:0] resp_ct,
  output logic         resp_err,
  aes_192_wb_master_if.master wb
);

  state_t                state;
  logic [191:0]          key_q;
  logic [127:0]          pt_q;
  logic [XFER_CNT_W-1:0] idx;
  logic [POLL_CNT_W-1:0] poll_cnt;
  logic [GAP_CNT_W-1:0]  gap_cnt;

  logic                  req;
  logic                  we;
  logic [WORD_W-1:0]     word;
  logic [31:0]           wdat;
  logic [31:0]           rdat;
  logic                  xfer_done;
  logic                  xfer_err;

`ifdef AES_WBM_KEY_CACHE_EN
  logic [191:0]          cache_key;
  logic                  cache_vld;
  logic                  key_hit;

  assign key_hit = cache_vld && (cache_key == cmd_key);
`endif

  // Decode the current state and word counter into the next bus request.
  always_comb begin
    req  = 1'b0;
    we   = 1'b0;
    word = START;
    wdat = 32'h0;
    case (state)
      WR_KEY: begin
        req  = 1'b1;
        we   = 1'b1;
        word = KEY0 + WORD_W'(idx);
        wdat = key_q[{idx, 5'b0} +: 32];
      end
      WR_DATA: begin
        req  = 1'b1;
        we   = 1'b1;
        word = DATA0 + WORD_W'(idx);
        wdat = pt_q[{idx[1:0], 5'b0} +: 32];
      end
      WR_START: begin
        req  = 1'b1;
        we   = 1'b1;
        word = START;
        wdat = 32'h1;
      end
      POLL: begin
        req  = (gap_cnt == '0);
        word = READY;
      end
      RD_RES: begin
        req  = 1'b1;
        word = RES0 + WORD_W'(idx);
      end
      default: begin
        req  = 1'b0;
      end
    endcase
  end

  wb_single_xfer u_xfer (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_i),
    .req   (req),
    .we    (we),
    .adr   (word_addr(BASE_ADDR, word)),
    .wdat  (wdat),
    .done  (xfer_done),
    .err   (xfer_err),
    .rdat  (rdat),
    .wb    (wb)
  );

  // Command sequencer: accept, write key/data/start, poll, read result, respond.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_ct    <= '0;
      resp_err   <= 1'b0;
      key_q      <= '0;
      pt_q       <= '0;
      idx        <= '0;
      poll_cnt   <= '0;
      gap_cnt    <= '0;
`ifdef AES_WBM_KEY_CACHE_EN
      cache_key  <= '0;
      cache_vld  <= 1'b0;
`endif
    end else if (xfer_err) begin
      state      <= RESP;
      resp_valid <= 1'b1;
      resp_err   <= 1'b1;
`ifdef AES_WBM_KEY_CACHE_EN
      cache_vld  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            key_q     <= cmd_key;
            pt_q      <= cmd_pt;
            resp_ct   <= '0;
            resp_err  <= 1'b0;
            idx       <= '0;
            poll_cnt  <= '0;
            gap_cnt   <= '0;
`ifdef AES_WBM_KEY_CACHE_EN
            state     <= key_hit ? WR_DATA : WR_KEY;
`else
            state     <= WR_KEY;
`endif
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR_KEY: begin
          if (xfer_done) begin
            if (idx == XFER_CNT_W'(5)) begin
              idx   <= '0;
              state <= WR_DATA;
`ifdef AES_WBM_KEY_CACHE_EN
              cache_key <= key_q;
              cache_vld <= 1'b1;
`endif
            end else begin
              idx <= idx + XFER_CNT_W'(1);
            end
          end
        end
        WR_DATA: begin
          if (xfer_done) begin
            if (idx == XFER_CNT_W'(3)) begin
              idx   <= '0;
              state <= WR_START;
            end else begin
              idx <= idx + XFER_CNT_W'(1);
            end
          end
        end
        WR_START: begin
          if (xfer_done) begin
            state <= POLL;
          end
        end
        POLL: begin
          if (xfer_done) begin
            if (rdat[0]) begin
              idx   <= '0;
              state <= RD_RES;
            end else if (poll_cnt == POLL_CNT_W'(POLL_MAX - 1)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
`ifdef AES_WBM_KEY_CACHE_EN
              cache_vld  <= 1'b0;
`endif
            end else begin
              poll_cnt <= poll_cnt + POLL_CNT_W'(1);
              gap_cnt  <= GAP_CNT_W'(POLL_GAP);
            end
          end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_CNT_W'(1);
          end
        end
        RD_RES: begin
          if (xfer_done) begin
            resp_ct[{idx[1:0], 5'b0} +: 32] <= rdat;
            if (idx == XFER_CNT_W'(3)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
            end else begin
              idx <= idx + XFER_CNT_W'(1);
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_192_wb_master.sv
// Directed testbench for aes_192_wb_master with a zero-wait AES slave model.
// The slave returns fixed FIPS-197 ciphertext words, a ready flag that rises
// on a programmable poll read, and can answer a chosen write with err+ack.
module tb_aes_192_wb_master;

  localparam logic [31:0]  BASE   = 32'h4000_0000;
  localparam logic [191:0] FKEY   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] FPT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FCT    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_i = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [191:0] cmd_key = '0;
  logic [127:0] cmd_pt = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [127:0] resp_ct;
  logic         resp_err;

  aes_192_wb_master_if bus();

  aes_192_wb_master #(
    .BASE_ADDR (BASE),
    .POLL_MAX  (4),
    .POLL_GAP  (2)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_key    (cmd_key),
    .cmd_pt     (cmd_pt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_ct    (resp_ct),
    .resp_err   (resp_err),
    .wb         (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCount = 0;

  // Slave model state
  logic [31:0] mem [16];
  int          pollReads = 0;
  int          pollBase = 0;
  int          readyAt = 1;
  logic        errEn = 1'b0;
  logic [3:0]  errWord = 4'd0;
  logic [3:0]  slvWord;
  logic        slvHit;

  assign slvWord = 4'((bus.wb_adr_o - BASE) >> 2);
  assign slvHit  = bus.wb_cyc_o & bus.wb_stb_o;
  assign bus.wb_ack_i = slvHit;
  assign bus.wb_err_i = slvHit & errEn & bus.wb_we_o & (slvWord == errWord);

  // Zero-wait read data: ready flag on word 11, fixed ciphertext on 12..15.
  always_comb begin
    bus.wb_dat_i = 32'h0;
    if (slvHit && !bus.wb_we_o) begin
      case (slvWord)
        4'd11:   bus.wb_dat_i = {31'd0, (readyAt != 0) && (pollReads - pollBase + 1 >= readyAt)};
        4'd12:   bus.wb_dat_i = 32'hec0d7191;
        4'd13:   bus.wb_dat_i = 32'h6eaf70a0;
        4'd14:   bus.wb_dat_i = 32'h864cdfe0;
        4'd15:   bus.wb_dat_i = 32'hdda97ca4;
        default: bus.wb_dat_i = mem[slvWord];
      endcase
    end
  end

  // Slave register file updates and poll counting.
  always @(posedge wb_clk_i) begin
    cycleCount <= cycleCount + 1;
    if (slvHit && bus.wb_we_o && !bus.wb_err_i) mem[slvWord] <= bus.wb_dat_o;
    if (slvHit && !bus.wb_we_o && slvWord == 4'd11) pollReads <= pollReads + 1;
  end

  // Bus monitor: log every completed transfer and flag a missing idle clock.
  int         nLog = 0;
  logic [3:0] logWord [512];
  logic       logWe [512];
  int         logEdge [512];
  int         gapViol = 0;
  logic       prevDone = 1'b0;

  always @(negedge wb_clk_i) begin
    if (bus.wb_cyc_o && prevDone) gapViol = gapViol + 1;
    prevDone = slvHit && (bus.wb_ack_i || bus.wb_err_i);
    if (prevDone && nLog < 512) begin
      logWord[nLog] = slvWord;
      logWe[nLog]   = bus.wb_we_o;
      logEdge[nLog] = cycleCount + 1;
      nLog = nLog + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    testsRun = testsRun + 1;
    if (obs !== exp) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command and return the clock edge on which it was accepted.
  task automatic applyStimulus(input logic [191:0] key, input logic [127:0] pt, input int rdy,
                               output int acceptEdge, output int logStart);
    @(posedge wb_clk_i); #1;
    readyAt   = rdy;
    pollBase  = pollReads;
    logStart  = nLog;
    cmd_key   = key;
    cmd_pt    = pt;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge wb_clk_i);
      if (cmd_ready) break;
    end
    if (!cmd_ready) checkOutput("cmd_ready_wait", 0, 1);
    acceptEdge = cycleCount + 1;
    @(posedge wb_clk_i); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic waitResponse(input int acceptEdge, output int lat);
    lat = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge wb_clk_i);
      if (resp_valid) begin
        lat = cycleCount - acceptEdge;
        break;
      end
    end
    if (lat < 0) checkOutput("resp_wait", 0, 1);
  endtask

  task automatic consumeResponse();
    @(posedge wb_clk_i); #1;
    resp_ready = 1'b1;
    @(posedge wb_clk_i); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc, ls, lat, cnt, bad, mark;
    logic [43:0] ord;
    int pe [4];

    // Reset state
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("rst_ctrl", {cmd_ready, resp_valid, resp_err, bus.wb_cyc_o, bus.wb_stb_o,
                             bus.wb_we_o, bus.wb_sel_o}, {1'b1, 9'b0});
    checkOutput("rst_bus", {bus.wb_adr_o, bus.wb_dat_o}, 64'h0);
    checkOutput("rst_ct", resp_ct, 128'h0);
    wb_rst_i = 1'b1;

    // 1: FIPS-197 vector, ready on first poll
    applyStimulus(FKEY, FPT, 1, acc, ls);
    waitResponse(acc, lat);
    checkOutput("t1_ct", resp_ct, FCT);
    checkOutput("t1_err", resp_err, 0);
    checkOutput("t1_lat", lat, 32);
    checkOutput("t1_xfers", nLog - ls, 16);
    ord = '0;
    for (int i = 0; i < 11; i++) ord = {ord[39:0], logWord[ls + i]};
    checkOutput("t1_order", ord, 44'h56789A12340);
    checkOutput("t1_wdata", {mem[0], mem[1], mem[4], mem[5], mem[10]},
                {32'h1, 32'hccddeeff, 32'h00112233, 32'h14151617, 32'h00010203});
    consumeResponse();
    @(negedge wb_clk_i);
    checkOutput("t1_hs_drop", {resp_valid, cmd_ready}, 2'b00);
    @(negedge wb_clk_i);
    checkOutput("t1_cmd_ready", cmd_ready, 1);

    // 2: ready after the third poll
    applyStimulus(192'h2, 128'h2, 3, acc, ls);
    waitResponse(acc, lat);
    cnt = 0;
    for (int i = ls; i < nLog; i++)
      if (!logWe[i] && logWord[i] == 4'd11 && cnt < 4) begin pe[cnt] = logEdge[i]; cnt++; end
    checkOutput("t2_polls", cnt, 3);
    checkOutput("t2_spacing", {16'(pe[1] - pe[0]), 16'(pe[2] - pe[1])}, {16'd4, 16'd4});
    checkOutput("t2_lat", lat, 40);
    checkOutput("t2_ct", {resp_err, resp_ct}, {1'b0, FCT});
    consumeResponse();

    // 3: ready never rises, timeout after POLL_MAX reads
    applyStimulus(192'h3, 128'h3, 0, acc, ls);
    waitResponse(acc, lat);
    cnt = 0;
    for (int i = ls; i < nLog; i++) if (!logWe[i] && logWord[i] == 4'd11) cnt++;
    checkOutput("t3_polls", cnt, 4);
    checkOutput("t3_resp", {resp_err, resp_ct}, {1'b1, 128'h0});
    checkOutput("t3_lat", lat, 36);
    consumeResponse();

    // 4: error (with simultaneous ack) on the write to word 3
    errEn = 1'b1;
    errWord = 4'd3;
    applyStimulus(192'h4, 128'h4, 1, acc, ls);
    waitResponse(acc, lat);
    checkOutput("t4_resp", {resp_err, resp_ct}, {1'b1, 128'h0});
    checkOutput("t4_lat", lat, 18);
    repeat (5) @(negedge wb_clk_i);
    checkOutput("t4_xfers", nLog - ls, 9);
    consumeResponse();
    errEn = 1'b0;
    applyStimulus(192'h5, 128'h5, 1, acc, ls);
    waitResponse(acc, lat);
    checkOutput("t4_next", {resp_err, resp_ct}, {1'b0, FCT});
    checkOutput("t4_next_lat", lat, 32);
    consumeResponse();

    // 5: stalled response, then reset in the middle of polling
    applyStimulus(192'h6, 128'h6, 1, acc, ls);
    waitResponse(acc, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk_i);
      if (!resp_valid || resp_err || resp_ct !== FCT) bad++;
    end
    checkOutput("t5_stable", bad, 0);
    consumeResponse();
    applyStimulus(192'h7, 128'h7, 0, acc, ls);
    for (int i = 0; i < 100; i++) begin
      @(negedge wb_clk_i);
      if (pollReads - pollBase >= 1) break;
    end
    checkOutput("t5_polled", (pollReads - pollBase >= 1), 1);
    #2 wb_rst_i = 1'b0;
    #1;
    checkOutput("t5_rst_out", {cmd_ready, resp_valid, resp_err, bus.wb_cyc_o, bus.wb_stb_o,
                               bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o, bus.wb_dat_o, resp_ct},
                {1'b1, 9'b0, 64'h0, 128'h0});
    mark = nLog;
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge wb_clk_i);
      if (resp_valid || !cmd_ready) bad++;
    end
    checkOutput("t5_no_resp", bad, 0);
    checkOutput("t5_bus_quiet", nLog - mark, 0);

`ifdef AES_WBM_KEY_CACHE_EN
    // 6: same key twice, second command skips the key writes
    applyStimulus(192'h8, 128'h8, 1, acc, ls);
    waitResponse(acc, lat);
    checkOutput("t6_first_lat", lat, 32);
    consumeResponse();
    applyStimulus(192'h8, 128'h9, 1, acc, ls);
    waitResponse(acc, lat);
    cnt = 0;
    for (int i = ls; i < nLog; i++) if (logWe[i] && logWord[i] >= 4'd5 && logWord[i] <= 4'd10) cnt++;
    checkOutput("t6_key_writes", cnt, 0);
    checkOutput("t6_second_lat", lat, 20);
    checkOutput("t6_ct", {resp_err, resp_ct}, {1'b0, FCT});
    consumeResponse();
`endif

    checkOutput("gap_idle", gapViol, 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
